// File: rtl/bitonic_topk_pipe.sv
// bitonic_topk_pipe: fully pipelined bitonic sorter with valid/ready flow.
// One compare-exchange level per register stage. Each beat carries its own
// direction bit. The first TOPK ranked values leave together with their
// original input indices.
module bitonic_topk_pipe #(
   parameter int DATAWIDTH  = 8,
   parameter int DATALENGTH = 16,
   parameter int TOPK       = 4,
   parameter bit SIGNED     = 1'b0
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          flush_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic                          desc_i,
   input  logic [DATAWIDTH-1:0]          x_i [DATALENGTH],
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          desc_o,
   output logic [DATAWIDTH-1:0]          y_o [TOPK],
   output logic [$clog2(DATALENGTH)-1:0] idx_o [TOPK],
   output logic                          busy_o
);

   localparam int IW     = $clog2(DATALENGTH);
   localparam int L      = IW;
   localparam int STAGES = L * (L + 1) / 2;

   typedef logic [DATAWIDTH-1:0] val_t;
   typedef logic [IW-1:0]        idx_t;

   // Stage register banks
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] d_q;
   val_t              val_q [STAGES][DATALENGTH];
   idx_t              idx_q [STAGES][DATALENGTH];

   // Per-stage network inputs and compare-exchange results
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] src_desc;
   val_t              src_val [STAGES][DATALENGTH];
   idx_t              src_idx [STAGES][DATALENGTH];
   val_t              ce_val  [STAGES][DATALENGTH];
   idx_t              ce_idx  [STAGES][DATALENGTH];

   logic [STAGES-1:0] adv;
   logic              accept;

   // True when element a must sit ahead of element b in the output order.
   // Equal values always put the lower original index first, so the order
   // is total and identical in both directions.
   function automatic logic ranks_first(input val_t a, input idx_t ia,
                                        input val_t b, input idx_t ib,
                                        input logic desc);
      logic gt;
      if (SIGNED) gt = ($signed(a) > $signed(b));
      else        gt = (a > b);
      if (a == b) return (ia < ib);
      return desc ? gt : ~gt;
   endfunction

   // Advance chain: a stage moves when it is empty or its successor moves.
   // The chain depends only on stage valids and ready_i, never on valid_i.
   always_comb begin
      logic a;
      // NOTE: every variable an always_comb writes gets a value before any
      // branch or loop, so no path can leave it holding state (no latch).
      a   = ready_i;
      adv = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
         a      = ~v_q[s] | a;
         adv[s] = a;
      end
   end

   assign ready_o = adv[0] & ~flush_i;
   assign accept  = valid_i & ready_o;

   // Network inputs: stage 0 takes the port vector tagged with indices 0..N-1.
   // Every later stage takes the register bank that precedes it.
   always_comb begin
      src_v       = '0;
      src_desc    = '0;
      src_v[0]    = accept;
      src_desc[0] = desc_i;
      for (int i = 0; i < DATALENGTH; i++) begin
         src_val[0][i] = x_i[i];
         src_idx[0][i] = idx_t'(i);
      end
      for (int s = 1; s < STAGES; s++) begin
         src_v[s]    = v_q[s-1];
         src_desc[s] = d_q[s-1];
         src_val[s]  = val_q[s-1];
         src_idx[s]  = idx_q[s-1];
      end
   end

   // Bitonic compare-exchange levels. The block size is k = 2^p and the
   // partner distance is j = 2^q. Stages are numbered in network order.
   // Sub-blocks with (i & k) == 0 put the higher-ranked element at the lower
   // position. Sub-blocks with (i & k) != 0 do the reverse.
   always_comb begin
      int   s;
      int   l;
      logic up;
      logic swap;
      s      = 0;
      l      = 0;
      up     = 1'b0;
      swap   = 1'b0;
      ce_val = src_val;
      ce_idx = src_idx;
      for (int p = 1; p <= L; p++) begin
         for (int q = p - 1; q >= 0; q--) begin
            for (int i = 0; i < DATALENGTH; i++) begin
               l = i ^ (1 << q);
               if (l > i) begin
                  up = (((i >> p) & 1) == 0);
                  if (up)
                     swap = ranks_first(src_val[s][l], src_idx[s][l],
                                        src_val[s][i], src_idx[s][i], src_desc[s]);
                  else
                     swap = ranks_first(src_val[s][i], src_idx[s][i],
                                        src_val[s][l], src_idx[s][l], src_desc[s]);
                  if (swap) begin
                     ce_val[s][i] = src_val[s][l];
                     ce_val[s][l] = src_val[s][i];
                     ce_idx[s][i] = src_idx[s][l];
                     ce_idx[s][l] = src_idx[s][i];
                  end
               end
            end
            s++;
         end
      end
   end

   // Stage registers: load on advance, hold otherwise; flush drops the valids
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         v_q   <= '0;
         d_q   <= '0;
         // NOTE: the data and index banks are reset as well, so y_o and idx_o
         // read zero straight out of reset; the valid bits alone gate the flow.
         val_q <= '{default: '0};
         idx_q <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignments, so every stage samples the
         // pre-edge value of its predecessor.
         for (int s = 0; s < STAGES; s++) begin
            if (flush_i)     v_q[s] <= 1'b0;
            else if (adv[s]) v_q[s] <= src_v[s];
            if (adv[s]) begin
               d_q[s]   <= src_desc[s];
               val_q[s] <= ce_val[s];
               idx_q[s] <= ce_idx[s];
            end
         end
      end
   end

   // Output view of the last stage: only the leading TOPK ranks leave
   always_comb begin
      valid_o = v_q[STAGES-1];
      desc_o  = d_q[STAGES-1];
      busy_o  = |v_q;
      for (int k = 0; k < TOPK; k++) begin
         y_o[k]   = val_q[STAGES-1][k];
         idx_o[k] = idx_q[STAGES-1][k];
      end
   end

endmodule

// File: tb/tb_bitonic_topk_pipe.sv
// Bench for bitonic_topk_pipe. The main instance is 16 elements, top 4,
// unsigned. A second instance is 8 elements, top 8, signed. It covers
// TOPK = DATALENGTH and two's-complement ordering.
module tb_bitonic_topk_pipe;

   localparam int DL  = 16;
   localparam int TK  = 4;
   localparam int IW  = 4;
   localparam int DL2 = 8;
   localparam int IW2 = 3;

   logic clk     = 1'b0;
   logic rstn    = 1'b0;
   logic flush   = 1'b0;
   logic valid_i = 1'b0;
   logic desc_i  = 1'b0;
   logic ready_i = 1'b1;
   logic ready_o, valid_o, desc_o, busy_o;
   logic [7:0]    x   [DL];
   logic [7:0]    y   [TK];
   logic [IW-1:0] idx [TK];

   logic s_valid_i = 1'b0;
   logic s_desc_i  = 1'b0;
   logic s_ready_i = 1'b1;
   logic s_ready_o, s_valid_o, s_desc_o, s_busy_o;
   logic [7:0]     s_x   [DL2];
   logic [7:0]     s_y   [DL2];
   logic [IW2-1:0] s_idx [DL2];

   bitonic_topk_pipe #(.DATAWIDTH(8), .DATALENGTH(DL), .TOPK(TK), .SIGNED(1'b0)) dut (
      .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
      .desc_i(desc_i), .x_i(x), .valid_o(valid_o), .ready_i(ready_i), .desc_o(desc_o),
      .y_o(y), .idx_o(idx), .busy_o(busy_o)
   );

   bitonic_topk_pipe #(.DATAWIDTH(8), .DATALENGTH(DL2), .TOPK(DL2), .SIGNED(1'b1)) dut_s (
      .clk_i(clk), .rstn_i(rstn), .flush_i(1'b0), .valid_i(s_valid_i), .ready_o(s_ready_o),
      .desc_i(s_desc_i), .x_i(s_x), .valid_o(s_valid_o), .ready_i(s_ready_i), .desc_o(s_desc_o),
      .y_o(s_y), .idx_o(s_idx), .busy_o(s_busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      logic [15:0] idx;
      logic        desc;
   } exp_t;

   exp_t exp_q [$];
   int   out_cyc_q [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t mon_e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] y_pack();
      return {y[0], y[1], y[2], y[3]};
   endfunction

   function automatic logic [15:0] idx_pack();
      return {idx[0], idx[1], idx[2], idx[3]};
   endfunction

   // Reference: repeated selection of the best unused element. A strict
   // comparison with an ascending scan keeps the lowest index among equals.
   function automatic void model(input logic [7:0] v [DL], input logic d,
                                 output logic [31:0] py, output logic [15:0] pi);
      bit used [DL];
      int best;
      py = '0;
      pi = '0;
      for (int i = 0; i < DL; i++) used[i] = 1'b0;
      for (int r = 0; r < TK; r++) begin
         best = -1;
         for (int i = 0; i < DL; i++) begin
            if (!used[i]) begin
               if (best < 0) best = i;
               else if (d ? (v[i] > v[best]) : (v[i] < v[best])) best = i;
            end
         end
         used[best] = 1'b1;
         py = {py[23:0], v[best]};
         pi = {pi[11:0], 4'(best)};
      end
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard: every transfer on the output must match the oldest expected beat
   always @(negedge clk) begin
      if (rstn && valid_o && ready_i) begin
         out_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("spurious_out", valid_o, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check("mon_y", y_pack(), mon_e.y);
            check("mon_idx", idx_pack(), mon_e.idx);
            check("mon_desc", desc_o, mon_e.desc);
         end
      end
   end

   // Present one beat; called and returning just after a rising edge
   task automatic send(input logic [7:0] v [DL], input logic d);
      exp_t e;
      x       = v;
      desc_i  = d;
      valid_i = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (ready_o) begin
            model(v, d, e.y, e.idx);
            e.desc = d;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            return;
         end
      end
      check("send_timeout", ready_o, 1'b1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic rand_vec(output logic [7:0] v [DL]);
      for (int i = 0; i < DL; i++) v[i] = 8'($urandom_range(0, 15));
   endtask

   task automatic wait_out(output int n);
      n = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         n++;
         if (valid_o) return;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 300; n++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_empty", 64'(exp_q.size()), 0);
   endtask

   // Single beat into the signed 8-element instance with full latency check
   task automatic send_s(input logic d, input logic [63:0] ey, input logic [23:0] ei);
      int n;
      s_desc_i  = d;
      s_valid_i = 1'b1;
      @(negedge clk);
      check("s_ready", s_ready_o, 1'b1);
      @(posedge clk);
      #1;
      s_valid_i = 1'b0;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         n++;
         if (s_valid_o) break;
      end
      check("s_latency", n, 6);
      check("s_y", {s_y[0], s_y[1], s_y[2], s_y[3], s_y[4], s_y[5], s_y[6], s_y[7]}, ey);
      check("s_idx", {s_idx[0], s_idx[1], s_idx[2], s_idx[3], s_idx[4], s_idx[5], s_idx[6], s_idx[7]}, ei);
      check("s_desc", s_desc_o, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  v [DL];
      logic [31:0] y_snap;
      logic [15:0] i_snap;
      int          n;
      int          base;

      for (int i = 0; i < DL; i++) x[i] = 8'h00;
      for (int i = 0; i < DL2; i++) s_x[i] = 8'h00;

      // Reset state
      #2;
      check("rst_valid", valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_y", y_pack(), 32'h0);
      check("rst_idx", idx_pack(), 16'h0);
      check("rst_desc", desc_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check("rst_ready", ready_o, 1'b1);
      @(posedge clk);
      #1;

      // First beat, descending: 9@1, 9@3, 7@5, then the first 6 is at index 9
      v = '{8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd7, 8'd2, 8'd4,
            8'd5, 8'd6, 8'd1, 8'd0, 8'd3, 8'd2, 8'd6, 8'd5};
      send(v, 1'b1);
      wait_out(n);
      check("first_latency", n, 10);
      check("first_y", y_pack(), 32'h09090706);
      check("first_idx", idx_pack(), {4'd1, 4'd3, 4'd5, 4'd9});
      check("first_desc", desc_o, 1'b1);
      @(negedge clk);
      check("first_pulse", valid_o, 1'b0);
      check("first_idle", busy_o, 1'b0);
      @(posedge clk);
      #1;

      // All-equal inputs: ties resolve by index in both directions
      for (int i = 0; i < DL; i++) v[i] = 8'h55;
      send(v, 1'b0);
      send(v, 1'b1);
      wait_out(n);
      check("eq_seen0", valid_o, 1'b1);
      check("eq_y0", y_pack(), 32'h55555555);
      check("eq_idx0", idx_pack(), 16'h0123);
      check("eq_desc0", desc_o, 1'b0);
      @(negedge clk);
      check("eq_seen1", valid_o, 1'b1);
      check("eq_idx1", idx_pack(), 16'h0123);
      check("eq_desc1", desc_o, 1'b1);
      @(posedge clk);
      #1;
      drain();

      // Signed ordering on the 8-element, full-output instance
      s_x = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
      send_s(1'b0, 64'h80FF00102030407F,
             {3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1});
      @(posedge clk);
      #1;
      send_s(1'b1, 64'h7F40302010_00FF80,
             {3'd1, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd0});
      @(posedge clk);
      #1;

      // Back-to-back stream, alternating direction
      base = out_cyc_q.size();
      for (int b = 0; b < 50; b++) begin
         rand_vec(v);
         send(v, 1'(b % 2));
      end
      drain();
      check("stream_count", 64'(out_cyc_q.size() - base), 50);
      check("stream_span", 64'(out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[base]), 49);
      @(posedge clk);
      #1;

      // Backpressure: 15 stalled cycles in the middle of a continuous stream
      base = out_cyc_q.size();
      fork
         begin
            logic [7:0] w [DL];
            for (int b = 0; b < 30; b++) begin
               rand_vec(w);
               send(w, 1'(b % 3 == 0));
            end
         end
         begin
            repeat (15) @(posedge clk);
            #1;
            ready_i = 1'b0;
            @(negedge clk);
            check("bp_valid", valid_o, 1'b1);
            y_snap = y_pack();
            i_snap = idx_pack();
            repeat (14) @(negedge clk);
            check("bp_ready_low", ready_o, 1'b0);
            check("bp_busy", busy_o, 1'b1);
            check("bp_hold_y", y_pack(), y_snap);
            check("bp_hold_idx", idx_pack(), i_snap);
            @(posedge clk);
            #1;
            ready_i = 1'b1;
         end
      join
      drain();
      check("bp_count", 64'(out_cyc_q.size() - base), 30);
      @(posedge clk);
      #1;

      // Flush with six beats in flight; the beat offered during flush is refused
      for (int b = 0; b < 6; b++) begin
         rand_vec(v);
         send(v, 1'b0);
      end
      rand_vec(v);
      x       = v;
      valid_i = 1'b1;
      flush   = 1'b1;
      @(negedge clk);
      check("flush_ready", ready_o, 1'b0);
      @(posedge clk);
      #1;
      flush   = 1'b0;
      valid_i = 1'b0;
      exp_q.delete();
      base = out_cyc_q.size();
      @(negedge clk);
      check("flush_valid", valid_o, 1'b0);
      check("flush_busy", busy_o, 1'b0);
      repeat (20) @(negedge clk);
      check("flush_no_out", 64'(out_cyc_q.size() - base), 0);
      @(posedge clk);
      #1;
      rand_vec(v);
      send(v, 1'b1);
      drain();
      @(posedge clk);
      #1;

      // Asynchronous reset mid-cycle with a stalled beat on the output
      ready_i = 1'b0;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < DL; i++) v[i] = 8'(8'h20 + i + b);
         send(v, 1'b1);
      end
      repeat (4) @(posedge clk);
      #3;
      check("rstm_pre_valid", valid_o, 1'b1);
      rstn = 1'b0;
      #1;
      check("rstm_valid", valid_o, 1'b0);
      check("rstm_busy", busy_o, 1'b0);
      check("rstm_y", y_pack(), 32'h0);
      check("rstm_idx", idx_pack(), 16'h0);
      check("rstm_desc", desc_o, 1'b0);
      exp_q.delete();
      ready_i = 1'b1;
      base = out_cyc_q.size();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      check("rstm_no_out", 64'(out_cyc_q.size() - base), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bitonic_topk_pipe.md
Name: bitonic_topk_pipe

Overview:
- Parametrised, fully pipelined bitonic sorter with valid/ready streaming for the top-k datapath.
- Accepts one DATALENGTH-element vector per beat and sorts it ascending or descending, selected per beat.
- Emits the first TOPK sorted values together with their original input indices.
- Generalises the fixed 8/16-input sorter tree: any power-of-two length, per-stage registers, backpressure, flush and index tracking.

Parameters:
- DATAWIDTH, 8, bit width of each element.
- DATALENGTH, 16, elements per vector; power of two, >= 2.
- TOPK, 4, number of leading sorted elements output; 1 <= TOPK <= DATALENGTH.
- SIGNED, 0, 1 = compare elements as two's complement, 0 = unsigned.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all in-flight beats.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- desc_i  in  1  1 = descending (largest first), 0 = ascending.
- x_i  in  DATAWIDTH x DATALENGTH  unpacked input vector; element i carries index i.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream ready.
- desc_o  out  1  desc_i of the beat being output.
- y_o  out  DATAWIDTH x TOPK  sorted values; y_o[0] is the highest-ranked element.
- idx_o  out  $clog2(DATALENGTH) x TOPK  original index of each y_o element.
- busy_o  out  1  OR of all stage valid bits.

Behaviour:
- Compare-exchange levels:
  - L = log2(DATALENGTH); STAGES = L*(L+1)/2 (10 for 16, 6 for 8, 1 for 2).
  - Each stage is one register bank holding valid, desc, DATALENGTH values and DATALENGTH indices.
- Ordering key:
  - Key is {value, index}; ties on value are resolved so the lower original index ranks first, in both directions.
  - Output order is therefore fully deterministic.
  - Value comparison is signed when SIGNED=1, otherwise unsigned.
- Per-beat direction:
  - Each stage's compare directions are derived from the desc bit carried in that stage.
  - Beats of mixed direction may be in flight simultaneously.
- Pipeline flow (bubble-collapsing):
  - Stage s advances when it is empty or stage s+1 advances.
  - The last stage advances when !valid_o || ready_i.
  - ready_o = stage-0 advance condition; this is purely combinational from stage valids and ready_i, with no combinational path from valid_i.
- Latency and throughput:
  - Latency from an accepted beat to valid_o is exactly STAGES cycles when there is no backpressure.
  - Throughput is one beat per cycle.
- Stall: while valid_o && !ready_i:
  - y_o, idx_o and desc_o are held stable.
  - Upstream stages keep filling until each holds a beat; then ready_o falls.
  - Beats are never dropped or duplicated.
- Output selection:
  - y_o and idx_o are elements 0..TOPK-1 of the last stage.
  - Remaining elements are discarded.
- Reset (rstn_i low, asynchronous):
  - All stage valids = 0, so valid_o = 0 and busy_o = 0.
  - ready_o = 1 once reset deasserts.
  - Data and index registers reset to 0, so y_o = 0, idx_o = 0, desc_o = 0.
  - A reset mid-stream discards every in-flight beat.
- Flush:
  - flush_i clears all stage valids on the next edge; data registers are not required to clear.
  - A beat presented with valid_i in the same cycle as flush_i is not accepted; ready_o = 0 while flush_i = 1.
  - valid_o = 0 in the cycle after flush_i.
- Boundaries:
  - DATALENGTH = 2 gives a single stage.
  - TOPK = DATALENGTH outputs the full sorted vector.
  - Combining all-equal inputs with tie-breaking yields idx_o = 0,1,2,... in both directions.

Test Plan:
- Reset release, then one beat:
  - Stimulus: DATALENGTH=16, TOPK=4, desc_i=1, x_i = {3,9,1,9,0,7,...}.
  - Required: after 10 cycles, y_o = {9,9,7,...}; idx_o begins {1,3,5}; valid_o pulses for one cycle with ready_i = 1.
- Back-to-back streaming:
  - Stimulus: 50 random beats with alternating desc_i and ready_i = 1.
  - Required: one output per cycle from cycle 10, order preserved, every beat matching the reference model, including the index tie-break.
- Backpressure:
  - Stimulus: stream continuously, hold ready_i = 0 for 15 cycles.
  - Required: ready_o falls once all 10 stages are full; outputs stay stable while stalled; after release, no beat is lost or duplicated.
- SIGNED = 1:
  - Stimulus: x_i containing 8'h80, 8'h7F, 8'hFF, 0, with desc_i = 0.
  - Required: y_o = {-128, -1, 0, ...} with the matching indices.
- All-equal inputs:
  - Stimulus: all elements = 8'h55, desc_i = 0 and then desc_i = 1.
  - Required: idx_o = {0,1,2,3} for both beats.
- Flush and reset mid-stream:
  - Stimulus: 6 beats in flight, pulse flush_i.
  - Required: valid_o and busy_o are 0 next cycle and no flushed beat ever appears.
  - Stimulus: repeat with rstn_i asserted asynchronously mid-cycle.
  - Required: outputs clear immediately.
